// File: rtl/wb_arb_pkg.sv
// Shared constants, types and the round-robin search for write-port arbitration.
package wb_arb_pkg;

  localparam int WB_N_REQ    = 4;
  localparam int WB_ADDR_W   = 5;
  localparam int WB_DATA_W   = 32;
  localparam int WB_ZERO_REG = 0;

  // rr_pick works on a fixed-size view so one function serves every N (2..8).
  localparam int RR_MAX_N = 8;
  localparam int RR_IDX_W = 3;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0], searching upward from ptr and wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t            r;
    logic [RR_IDX_W-1:0] j;
    r = '0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      if (k < n && !r.found) begin
        j = RR_IDX_W'((int'(ptr) + k) % n);
        if (valid[j]) begin
          r.found = 1'b1;
          r.idx   = j;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: rotating pointer plus one-hot grant.
// Handshake: ready[i] is only raised on a valid requester; a transfer happens
// in any cycle where valid[i] & ready[i], and the requester must hold its
// request stable until then. stall suppresses every grant and freezes ptr.
module rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int N  = WB_N_REQ,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic [N-1:0]  valid,
  input  logic          stall,
  output logic [N-1:0]  ready,
  output logic          grant_vld,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  rr_pick_t      pick;

  // Grant decision and next pointer (one past the winner, wrapping at N).
  always_comb begin
    pick      = rr_pick(RR_MAX_N'(valid), RR_IDX_W'(ptr_q), N);
    grant_vld = pick.found & ~stall;
    grant_idx = IW'(pick.idx);
    ready     = '0;
    ptr_d     = ptr_q;
    if (grant_vld) begin
      ready[grant_idx] = 1'b1;
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among N_REQ result producers, one
// registered write per cycle. Writes to x0 complete the handshake but never
// raise wr_en.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int N_REQ  = WB_N_REQ,
  parameter  int DATA_W = WB_DATA_W,
  parameter  int ADDR_W = WB_ADDR_W,
  localparam int GW     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    wr_stall,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [GW-1:0]           grant_id
);

  logic              grant_vld;
  logic [GW-1:0]     grant_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,  wr_data_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk       (clk),
    .arst_n    (arst_n),
    .valid     (req_valid),
    .stall     (wr_stall),
    .ready     (req_ready),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // Select the winner's payload and form the next output-stage contents.
  always_comb begin
    sel_addr   = req_addr[grant_idx*ADDR_W +: ADDR_W];
    sel_data   = req_data[grant_idx*DATA_W +: DATA_W];
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    if (grant_vld) begin
      wr_en_d    = (sel_addr != ADDR_W'(WB_ZERO_REG));
      wr_addr_d  = sel_addr;
      wr_data_d  = sel_data;
      grant_id_d = grant_idx;
    end
  end

  // Output register; async reset drops wr_en without waiting for a clock.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_id_q;

endmodule
